// File: rtl/game_pkg.sv
// Shared definitions for the N x N game controller: FSM states, outcome codes, turn values.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_PLAYER_WAIT,
      ST_AGENT_WAIT,
      ST_EVAL,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      OUT_NONE   = 2'b00,
      OUT_AGENT  = 2'b01,
      OUT_PLAYER = 2'b10,
      OUT_DRAW   = 2'b11
   } outcome_t;

   localparam logic TURN_PLAYER = 1'b0;
   localparam logic TURN_AGENT  = 1'b1;

endpackage

// File: rtl/line_detector.sv
// Combinational N-in-a-row detector: flags any complete row, column or diagonal in a bitmap.
module line_detector #(
   parameter int BOARD_N = 3
) (
   input  logic [BOARD_N*BOARD_N-1:0] bits_i,
   output logic                       line_o
);

   logic [BOARD_N-1:0] row_ok;
   logic [BOARD_N-1:0] col_ok;
   logic [BOARD_N-1:0] diag_v;
   logic [BOARD_N-1:0] anti_v;

   for (genvar r = 0; r < BOARD_N; r++) begin : g_row
      assign row_ok[r] = &bits_i[r*BOARD_N +: BOARD_N];
      assign diag_v[r] = bits_i[r*BOARD_N + r];
      assign anti_v[r] = bits_i[r*BOARD_N + (BOARD_N-1-r)];
   end

   for (genvar c = 0; c < BOARD_N; c++) begin : g_col
      logic [BOARD_N-1:0] col_v;
      for (genvar r = 0; r < BOARD_N; r++) begin : g_cell
         assign col_v[r] = bits_i[r*BOARD_N + c];
      end
      assign col_ok[c] = &col_v;
   end

   assign line_o = (|row_ok) | (|col_ok) | (&diag_v) | (&anti_v);

endmodule

// File: rtl/game_controller.sv
// N x N board owner: sequences player/agent turns, validates moves, detects win and draw.
module game_controller
   import game_pkg::*;
#(
   parameter int BOARD_N     = 3,
   parameter int IDX_W       = 4,
   parameter int FIRST_MOVER = 0
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic                       start,
   input  logic [IDX_W-1:0]           action,
   input  logic                       action_valid,
   output logic                       en_policygen,
   input  logic [IDX_W-1:0]           agent_action,
   input  logic                       agent_valid,
   output logic [BOARD_N*BOARD_N-1:0] board_player,
   output logic [BOARD_N*BOARD_N-1:0] board_agent,
   output logic                       turn,
   output logic                       illegal_move,
   output logic [1:0]                 outcome
);

   localparam int             CELLS      = BOARD_N * BOARD_N;
   localparam logic [IDX_W:0] CELLS_L    = (IDX_W+1)'(CELLS);
   localparam logic           FIRST_TURN = (FIRST_MOVER != 0) ? TURN_AGENT : TURN_PLAYER;

   state_t             state_q, state_d;
   logic [CELLS-1:0]   bp_q, bp_d;
   logic [CELLS-1:0]   ba_q, ba_d;
   logic               turn_q, turn_d;
   logic               ill_q, ill_d;
   outcome_t           out_q, out_d;

   logic [CELLS-1:0]   occ, oh_p, oh_a, mover_bits;
   logic               legal_p, legal_a, line_c, full_c;

   // Out-of-range indices shift the one-hot to zero; the range compare rejects them.
   always_comb begin
      occ     = bp_q | ba_q;
      oh_p    = {{(CELLS-1){1'b0}}, 1'b1} << action;
      oh_a    = {{(CELLS-1){1'b0}}, 1'b1} << agent_action;
      legal_p = ({1'b0, action} < CELLS_L) && ((occ & oh_p) == '0);
      legal_a = ({1'b0, agent_action} < CELLS_L) && ((occ & oh_a) == '0);
      full_c  = &occ;
      mover_bits = (turn_q == TURN_AGENT) ? ba_q : bp_q;
   end

   line_detector #(.BOARD_N(BOARD_N)) u_line (
      .bits_i (mover_bits),
      .line_o (line_c)
   );

   always_comb begin
      state_d = state_q;
      bp_d    = bp_q;
      ba_d    = ba_q;
      turn_d  = turn_q;
      ill_d   = 1'b0;
      out_d   = out_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_CLEAR;
               bp_d    = '0;
               ba_d    = '0;
               out_d   = OUT_NONE;
            end
         end
         ST_CLEAR: begin
            turn_d  = FIRST_TURN;
            state_d = (FIRST_TURN == TURN_AGENT) ? ST_AGENT_WAIT : ST_PLAYER_WAIT;
         end
         ST_PLAYER_WAIT: begin
            if (action_valid) begin
               if (legal_p) begin
                  bp_d    = bp_q | oh_p;
                  state_d = ST_EVAL;
               end else begin
                  ill_d = 1'b1;
               end
            end
         end
         ST_AGENT_WAIT: begin
            if (agent_valid) begin
               if (legal_a) begin
                  ba_d    = ba_q | oh_a;
                  state_d = ST_EVAL;
               end else begin
                  ill_d = 1'b1;
               end
            end
         end
         ST_EVAL: begin
            if (line_c) begin
               out_d   = (turn_q == TURN_AGENT) ? OUT_AGENT : OUT_PLAYER;
               state_d = ST_DONE;
            end else if (full_c) begin
               out_d   = OUT_DRAW;
               state_d = ST_DONE;
            end else begin
               turn_d  = ~turn_q;
               state_d = (turn_q == TURN_AGENT) ? ST_PLAYER_WAIT : ST_AGENT_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         bp_q    <= '0;
         ba_q    <= '0;
         turn_q  <= FIRST_TURN;
         ill_q   <= 1'b0;
         out_q   <= OUT_NONE;
      end else if (enable) begin
         state_q <= state_d;
         bp_q    <= bp_d;
         ba_q    <= ba_d;
         turn_q  <= turn_d;
         ill_q   <= ill_d;
         out_q   <= out_d;
      end
   end

   assign en_policygen = (state_q == ST_AGENT_WAIT);
   assign board_player = bp_q;
   assign board_agent  = ba_q;
   assign turn         = turn_q;
   assign illegal_move = ill_q;
   assign outcome      = out_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: default 3x3 player-first instance plus a 4x4 agent-first instance.
module tb_game_controller;
   import game_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, enable;
   logic        start1, av1, agv1;
   logic [3:0]  act1, agact1;
   logic        epg1, turn1, ill1;
   logic [8:0]  bp1, ba1;
   logic [1:0]  out1;

   logic        start2, av2, agv2;
   logic [3:0]  act2, agact2;
   logic        epg2, turn2, ill2;
   logic [15:0] bp2, ba2;
   logic [1:0]  out2;

   game_controller #(.BOARD_N(3), .IDX_W(4), .FIRST_MOVER(0)) dut (
      .clock(clk), .reset_n(rst_n), .enable(enable), .start(start1),
      .action(act1), .action_valid(av1), .en_policygen(epg1),
      .agent_action(agact1), .agent_valid(agv1),
      .board_player(bp1), .board_agent(ba1), .turn(turn1),
      .illegal_move(ill1), .outcome(out1)
   );

   game_controller #(.BOARD_N(4), .IDX_W(4), .FIRST_MOVER(1)) dut4 (
      .clock(clk), .reset_n(rst_n), .enable(enable), .start(start2),
      .action(act2), .action_valid(av2), .en_policygen(epg2),
      .agent_action(agact2), .agent_valid(agv2),
      .board_player(bp2), .board_agent(ba2), .turn(turn2),
      .illegal_move(ill2), .outcome(out2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Outcome scoreboard: expected codes queued with the deciding move, popped when outcome rises.
   logic [1:0] exp_q1[$];
   logic [1:0] exp_q2[$];
   logic [1:0] prev1 = 2'b00, prev2 = 2'b00;

   always @(negedge clk) begin
      if (prev1 == 2'b00 && out1 != 2'b00) begin
         if (exp_q1.size() == 0) check("sb3_unexpected", {30'd0, out1}, 32'd0);
         else                    check("sb3_outcome", {30'd0, out1}, {30'd0, exp_q1.pop_front()});
      end
      if (prev2 == 2'b00 && out2 != 2'b00) begin
         if (exp_q2.size() == 0) check("sb4_unexpected", {30'd0, out2}, 32'd0);
         else                    check("sb4_outcome", {30'd0, out2}, {30'd0, exp_q2.pop_front()});
      end
      prev1 = out1;
      prev2 = out2;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pboard(input bit d2);
      return d2 ? bp2 : {7'd0, bp1};
   endfunction

   function automatic logic [15:0] aboard(input bit d2);
      return d2 ? ba2 : {7'd0, ba1};
   endfunction

   task automatic do_start(input bit d2);
      if (d2) start2 = 1'b1; else start1 = 1'b1;
      tick;
      start1 = 1'b0;
      start2 = 1'b0;
      tick;
   endtask

   task automatic pmove(input bit d2, input logic [3:0] idx);
      logic [15:0] b;
      if (d2) begin act2 = idx; av2 = 1'b1; end
      else    begin act1 = idx; av1 = 1'b1; end
      tick;
      av1 = 1'b0;
      av2 = 1'b0;
      b = pboard(d2);
      check("player_mark", {31'd0, b[idx]}, 32'd1);
      tick;
   endtask

   task automatic wait_req(input bit d2);
      int n = 0;
      while (!(d2 ? epg2 : epg1) && n < 6) begin
         tick;
         n++;
      end
      check("agent_request", {31'd0, d2 ? epg2 : epg1}, 32'd1);
   endtask

   task automatic amove(input bit d2, input logic [3:0] idx);
      logic [15:0] b;
      wait_req(d2);
      if (d2) begin agact2 = idx; agv2 = 1'b1; end
      else    begin agact1 = idx; agv1 = 1'b1; end
      tick;
      agv1 = 1'b0;
      agv2 = 1'b0;
      b = aboard(d2);
      check("agent_mark", {31'd0, b[idx]}, 32'd1);
      check("agent_request_drop", {31'd0, d2 ? epg2 : epg1}, 32'd0);
      tick;
   endtask

   task automatic pillegal(input logic [3:0] idx);
      logic [17:0] snap;
      snap = {bp1, ba1};
      act1 = idx;
      av1  = 1'b1;
      tick;
      av1 = 1'b0;
      check("player_illegal_pulse", {31'd0, ill1}, 32'd1);
      tick;
      check("player_illegal_end", {31'd0, ill1}, 32'd0);
      check("player_illegal_board", {14'd0, bp1, ba1}, {14'd0, snap});
   endtask

   task automatic aillegal(input logic [3:0] idx);
      agact1 = idx;
      agv1   = 1'b1;
      tick;
      agv1 = 1'b0;
      check("agent_illegal_pulse", {31'd0, ill1}, 32'd1);
      check("agent_illegal_req", {31'd0, epg1}, 32'd1);
      tick;
      check("agent_illegal_end", {31'd0, ill1}, 32'd0);
      check("agent_illegal_req_held", {31'd0, epg1}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [22:0] snap;
      rst_n = 1'b0; enable = 1'b1;
      start1 = 1'b0; av1 = 1'b0; agv1 = 1'b0; act1 = '0; agact1 = '0;
      start2 = 1'b0; av2 = 1'b0; agv2 = 1'b0; act2 = '0; agact2 = '0;
      tick;
      tick;
      check("rst_board_player", {23'd0, bp1}, 32'd0);
      check("rst_board_agent", {23'd0, ba1}, 32'd0);
      check("rst_outcome", {30'd0, out1}, 32'd0);
      check("rst_en_policygen", {31'd0, epg1}, 32'd0);
      check("rst_illegal", {31'd0, ill1}, 32'd0);
      check("rst_turn", {31'd0, turn1}, 32'd0);
      check("rst_turn_agent_first", {31'd0, turn2}, 32'd1);
      check("rst_en_policygen_4x4", {31'd0, epg2}, 32'd0);
      rst_n = 1'b1;
      tick;

      // Mid-game asynchronous reset with four marks on the board
      do_start(0);
      pmove(0, 0); amove(0, 4); pmove(0, 1); amove(0, 5);
      check("midgame_player", {23'd0, bp1}, 32'h003);
      check("midgame_agent", {23'd0, ba1}, 32'h030);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_player", {23'd0, bp1}, 32'd0);
      check("async_rst_agent", {23'd0, ba1}, 32'd0);
      check("async_rst_outcome", {30'd0, out1}, 32'd0);
      check("async_rst_en_policygen", {31'd0, epg1}, 32'd0);
      tick;
      rst_n = 1'b1;
      tick;
      act1 = 4'd3; av1 = 1'b1;
      tick;
      av1 = 1'b0;
      check("idle_ignores_move", {23'd0, bp1}, 32'd0);

      // Player row win and two-cycle outcome latency
      do_start(0);
      pmove(0, 0); amove(0, 4); pmove(0, 1); amove(0, 5);
      exp_q1.push_back(OUT_PLAYER);
      act1 = 4'd2; av1 = 1'b1;
      tick;
      av1 = 1'b0;
      check("win_board", {23'd0, bp1}, 32'h007);
      check("win_latency_1", {30'd0, out1}, 32'd0);
      tick;
      check("win_latency_2", {30'd0, out1}, {30'd0, OUT_PLAYER});
      check("win_no_request", {31'd0, epg1}, 32'd0);
      act1 = 4'd6; av1 = 1'b1;
      tick;
      av1 = 1'b0;
      check("done_ignores_move", {23'd0, bp1}, 32'h007);
      check("done_outcome_held", {30'd0, out1}, {30'd0, OUT_PLAYER});

      // Illegal moves, wrong-turn strobes, start ignored mid-game
      do_start(0);
      check("restart_clear_player", {23'd0, bp1}, 32'd0);
      check("restart_clear_outcome", {30'd0, out1}, 32'd0);
      pmove(0, 4);
      wait_req(0);
      aillegal(4);
      act1 = 4'd3; av1 = 1'b1;
      tick;
      av1 = 1'b0;
      check("wrong_turn_no_pulse", {31'd0, ill1}, 32'd0);
      check("wrong_turn_no_mark", {23'd0, bp1}, 32'h010);
      amove(0, 0);
      pillegal(4'd9);
      pillegal(4'd15);
      pillegal(4'd0);
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      tick;
      check("start_ignored_player", {23'd0, bp1}, 32'h010);
      check("start_ignored_agent", {23'd0, ba1}, 32'h001);
      pmove(0, 1); amove(0, 2);
      exp_q1.push_back(OUT_PLAYER);
      pmove(0, 7);
      check("col_win", {30'd0, out1}, {30'd0, OUT_PLAYER});

      // Start beats a simultaneous move strobe; then a full-board draw
      start1 = 1'b1; av1 = 1'b1; act1 = 4'd0;
      tick;
      start1 = 1'b0; av1 = 1'b0;
      tick;
      check("start_wins_strobe", {23'd0, bp1}, 32'd0);
      pmove(0, 0); amove(0, 1); pmove(0, 2); amove(0, 4); pmove(0, 3);
      amove(0, 5); pmove(0, 7); amove(0, 6);
      exp_q1.push_back(OUT_DRAW);
      pmove(0, 8);
      check("draw_outcome", {30'd0, out1}, {30'd0, OUT_DRAW});
      check("draw_full", {23'd0, bp1 | ba1}, 32'h1FF);

      // Last cell completes a line: win outranks draw
      do_start(0);
      pmove(0, 0); amove(0, 1); pmove(0, 2); amove(0, 3); pmove(0, 5);
      amove(0, 7); pmove(0, 6); amove(0, 8);
      exp_q1.push_back(OUT_PLAYER);
      pmove(0, 4);
      check("win_over_draw", {30'd0, out1}, {30'd0, OUT_PLAYER});

      // Agent diagonal win with a 10-cycle enable freeze during the agent's turn
      do_start(0);
      pmove(0, 1); amove(0, 0); pmove(0, 2);
      wait_req(0);
      snap = {epg1, turn1, ill1, out1, bp1, ba1};
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         agact1 = 4'd4; agv1 = 1'b1;
         act1 = 4'd3; av1 = 1'b1;
         tick;
         check("freeze_hold", {9'd0, epg1, turn1, ill1, out1, bp1, ba1}, {9'd0, snap});
      end
      agv1 = 1'b0; av1 = 1'b0;
      enable = 1'b1;
      amove(0, 4); pmove(0, 3);
      exp_q1.push_back(OUT_AGENT);
      amove(0, 8);
      check("agent_diag_win", {30'd0, out1}, {30'd0, OUT_AGENT});

      // 4x4 agent-first instance: column 1 win
      do_start(1);
      check("agent_first_request", {31'd0, epg2}, 32'd1);
      amove(1, 1); pmove(1, 0); amove(1, 5); pmove(1, 2); amove(1, 9); pmove(1, 3);
      exp_q2.push_back(OUT_AGENT);
      amove(1, 13);
      check("agent_col_win_4x4", {30'd0, out2}, {30'd0, OUT_AGENT});
      check("board_agent_4x4", {16'd0, ba2}, 32'h2222);

      tick;
      check("scoreboard3_drained", exp_q1.size(), 32'd0);
      check("scoreboard4_drained", exp_q2.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
